// File: rtl/rv_alu_pkg.sv
// Shared ALU definitions: op codes, default widths and the execute-stage entry layout.
// The ALU control decoder and the execute stage both import this package.
package rv_alu_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef struct packed {
    logic [XLEN_DEF-1:0]  result;
    logic                 zero;
    logic                 illegal;
    logic [TAG_W_DEF-1:0] rd;
  } alu_entry_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: (op, a, b) -> (result, zero, illegal).
module alu_core
  import rv_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = '0;
    endcase
  end

  assign illegal = !op_is_legal(op);
  assign zero    = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a 2-entry skid buffer; in_ready is a flop so downstream
// stalls never reach decode combinationally.
module alu_exec_stage
  import rv_alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] rd_out
);

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] rd;
  } stage_entry_t;

  localparam stage_entry_t RESET_ENTRY = '{result: '0, zero: 1'b1, illegal: 1'b0, rd: '0};

  stage_entry_t     main_q;
  stage_entry_t     skid_q;
  stage_entry_t     new_entry;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic             in_ready_q;
  logic             accept;
  logic             pop;
  logic [XLEN-1:0]  core_result;
  logic             core_zero;
  logic             core_illegal;

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (core_result),
    .zero    (core_zero),
    .illegal (core_illegal)
  );

  assign new_entry = '{result: core_result, zero: core_zero, illegal: core_illegal, rd: rd_in};

  assign out_valid = (occ_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      in_ready_q <= 1'b1;
      main_q     <= RESET_ENTRY;
      skid_q     <= RESET_ENTRY;
    end else if (flush) begin
      // Data registers keep their contents; they are meaningless once occ is 0.
      occ_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= (occ_d != 2'd2);
      if (accept && ((occ_q == 2'd0) || pop)) begin
        main_q <= new_entry;
      end else if (pop && (occ_q == 2'd2)) begin
        main_q <= skid_q;
      end
      if (accept && !pop && (occ_q == 2'd1)) begin
        skid_q <= new_entry;
      end
    end
  end

  assign result  = main_q.result;
  assign zero    = main_q.zero;
  assign illegal = main_q.illegal;
  assign rd_out  = main_q.rd;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, scoreboard on the
// output handshake, and hand-written backpressure/flush/reset sequences.
module tb_alu_exec_stage;
  import rv_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    exp_t        exp;
  } vec_t;

  exp_t  cur_exp;
  exp_t  sb_head;
  exp_t  sb_q[$];
  vec_t  vecs[11];
  int    tests    = 0;
  int    failures = 0;
  int    pops     = 0;
  int    pops_before;

  alu_exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: handshakes are decided by values stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          failures++;
          $display("FAIL sb_underflow: got output result %h rd %0d, expected no output", result, rd_out);
        end else begin
          sb_head = sb_q.pop_front();
          pops++;
          check("sb_result", result, sb_head.result);
          check_bit("sb_zero", zero, sb_head.zero);
          check_bit("sb_illegal", illegal, sb_head.illegal);
          check("sb_rd", 32'(rd_out), 32'(sb_head.rd));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  function automatic vec_t mk(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                              input logic [4:0] r, input logic [31:0] res, input logic z,
                              input logic il);
    vec_t v;
    v.op  = o;
    v.a   = aa;
    v.b   = bb;
    v.rd  = r;
    v.exp.result  = res;
    v.exp.zero    = z;
    v.exp.illegal = il;
    v.exp.rd      = r;
    return v;
  endfunction

  task automatic set_op(input vec_t v);
    op       = v.op;
    a        = v.a;
    b        = v.b;
    rd_in    = v.rd;
    cur_exp  = v.exp;
    in_valid = 1'b1;
  endtask

  // Returns #1 after the edge at which the presented op was accepted.
  task automatic wait_accept();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) begin
      tests++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) break;
    end
    if (n == 60) begin
      tests++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(ALU_ADD, 32'd5,          32'd7,          5'd3,  32'd12,         1'b0, 1'b0);
    vecs[1]  = mk(ALU_SUB, 32'd9,          32'd9,          5'd4,  32'd0,          1'b1, 1'b0);
    vecs[2]  = mk(ALU_ADD, 32'hFFFF_FFFF,  32'd1,          5'd5,  32'd0,          1'b1, 1'b0);
    vecs[3]  = mk(ALU_SUB, 32'd0,          32'd1,          5'd6,  32'hFFFF_FFFF,  1'b0, 1'b0);
    vecs[4]  = mk(ALU_AND, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  5'd7,  32'h00F0_00F0,  1'b0, 1'b0);
    vecs[5]  = mk(ALU_OR,  32'd0,          32'd0,          5'd8,  32'd0,          1'b1, 1'b0);
    vecs[6]  = mk(4'b0111, 32'd3,          32'd4,          5'd9,  32'd0,          1'b1, 1'b1);
    vecs[7]  = mk(ALU_OR,  32'h1234_0000,  32'h0000_5678,  5'd31, 32'h1234_5678,  1'b0, 1'b0);
    vecs[8]  = mk(4'b1111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'd0,          1'b1, 1'b1);
    vecs[9]  = mk(ALU_SUB, 32'd5,          32'd7,          5'd2,  32'hFFFF_FFFE,  1'b0, 1'b0);
    vecs[10] = mk(ALU_AND, 32'hFFFF_FFFF,  32'd0,          5'd0,  32'd0,          1'b1, 1'b0);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; a = '0; b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_zero", zero, 1'b1);
    check("rst_result", result, 32'd0);
    check_bit("rst_illegal", illegal, 1'b0);
    check("rst_rd", 32'(rd_out), 32'd0);
    @(posedge clk); #1;

    // Directed table, one op at a time into an empty buffer.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_op(vecs[i]);
      wait_accept();
      in_valid = 1'b0;
      check_bit("lat_out_valid", out_valid, 1'b1);
      check("lat_result", result, vecs[i].exp.result);
      check("lat_rd", 32'(rd_out), 32'(vecs[i].rd));
      @(posedge clk); #1;
    end
    wait_drain();

    // Backpressure fill.
    out_ready = 1'b0;
    set_op(mk(ALU_ADD, 32'd1, 32'd1, 5'd1, 32'd2, 1'b0, 1'b0));
    wait_accept();
    set_op(mk(ALU_ADD, 32'd2, 32'd2, 5'd2, 32'd4, 1'b0, 1'b0));
    wait_accept();
    check_bit("bp_in_ready_full", in_ready, 1'b0);
    check_bit("bp_out_valid", out_valid, 1'b1);
    set_op(mk(ALU_ADD, 32'd3, 32'd3, 5'd3, 32'd6, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("bp_hold_in_ready", in_ready, 1'b0);
      check("bp_hold_result", result, 32'd2);
      check_bit("bp_hold_zero", zero, 1'b0);
      check("bp_hold_rd", 32'(rd_out), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    check_bit("bp_no_gap_valid", out_valid, 1'b1);
    check("bp_third_result", result, 32'd6);
    wait_drain();

    // Streaming at full rate.
    pops_before = pops;
    for (int i = 0; i < 16; i++) begin
      set_op(mk(ALU_ADD, 32'(i), 32'(i), 5'(i), 32'(2 * i), (i == 0), 1'b0));
      @(negedge clk);
      check_bit("stream_in_ready", in_ready, 1'b1);
      if (i > 0) check_bit("stream_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check("stream_count", pops - pops_before, 32'd16);

    // Flush with the buffer full and an op presented.
    out_ready = 1'b0;
    set_op(mk(ALU_ADD, 32'd10, 32'd10, 5'd10, 32'd20, 1'b0, 1'b0));
    wait_accept();
    set_op(mk(ALU_ADD, 32'd11, 32'd11, 5'd11, 32'd22, 1'b0, 1'b0));
    wait_accept();
    set_op(mk(ALU_ADD, 32'd8, 32'd8, 5'd12, 32'd16, 1'b0, 1'b0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_bit("flush_full_out_valid", out_valid, 1'b0);
    check_bit("flush_full_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("flush_full_stays_empty", out_valid, 1'b0);
      check_bit("flush_full_no16", result == 32'd16, 1'b0);
    end
    @(posedge clk); #1;

    // Flush with one entry and in_ready=1: the presented op must still be dropped.
    out_ready = 1'b0;
    set_op(mk(ALU_ADD, 32'd7, 32'd7, 5'd13, 32'd14, 1'b0, 1'b0));
    wait_accept();
    set_op(mk(ALU_ADD, 32'd8, 32'd8, 5'd12, 32'd16, 1'b0, 1'b0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_bit("flush_one_out_valid", out_valid, 1'b0);
    check_bit("flush_one_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("flush_one_stays_empty", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Mid-stream reset with a full buffer.
    out_ready = 1'b0;
    set_op(mk(ALU_ADD, 32'd1, 32'd2, 5'd5, 32'd3, 1'b0, 1'b0));
    wait_accept();
    set_op(mk(ALU_ADD, 32'd3, 32'd4, 5'd6, 32'd7, 1'b0, 1'b0));
    wait_accept();
    in_valid = 1'b0;
    check_bit("mrst_full_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_bit("mrst_out_valid", out_valid, 1'b0);
    check_bit("mrst_in_ready", in_ready, 1'b1);
    check("mrst_result", result, 32'd0);
    check_bit("mrst_zero", zero, 1'b1);
    check("mrst_rd", 32'(rd_out), 32'd0);
    check_bit("mrst_illegal", illegal, 1'b0);
    out_ready = 1'b1;
    set_op(mk(ALU_SUB, 32'd100, 32'd58, 5'd9, 32'd42, 1'b0, 1'b0));
    wait_accept();
    in_valid = 1'b0;
    check("mrst_after_result", result, 32'd42);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two XLEN-bit operands and a destination register tag.
- Computes the result and zero flag and registers them into a 2-entry skid buffer with valid/ready handshakes on both sides.
- in_ready is driven from a flop, so a memory/writeback stall never forms a combinational path back into decode.
- A flush input empties the stage on a branch redirect.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 5, destination register tag width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; synchronous, active-low.
- flush  input  1  discard all buffered and incoming ops.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  stage can accept (registered).
- op  input  4  ALU operation code from ALU control.
- a  input  XLEN  operand A.
- b  input  XLEN  operand B.
- rd_in  input  TAG_W  destination tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts.
- result  output  XLEN  head entry result.
- zero  output  1  head result == 0.
- illegal  output  1  head op code unsupported.
- rd_out  output  TAG_W  head entry tag.

Behaviour:
- Op codes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - ADD and SUB wrap modulo 2^XLEN; no carry or overflow outputs.
  - Any other code gives result=0, zero=1, illegal=1.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Computation is combinational on the accepted inputs. The full entry {result, zero, illegal, rd} is captured at the accept edge.
- Latency: an op accepted at edge N is visible on the outputs (out_valid=1) after edge N if the buffer was empty.
- Throughput: 1 op/cycle when out_ready stays high.
- Storage: main entry (drives the outputs) plus skid entry. Occupancy count occ takes values 0..2.
  - in_ready = (occ < 2), held as a flop updated every edge.
  - out_valid = (occ > 0).
- Transitions, evaluated at each edge:
  - accept only, occ=0: write main; occ becomes 1.
  - accept only, occ=1: write skid; occ becomes 2.
  - pop only, occ=2: skid moves to main; occ becomes 1.
  - pop only, occ=1: occ becomes 0.
  - accept + pop, occ=1: main is overwritten with the new op; occ stays 1.
  - accept + pop, occ=2: cannot occur, because in_ready=0.
  - neither: hold.
- Ordering is strictly FIFO.
- Output stability: while out_valid=1 and out_ready=0, result, zero, illegal and rd_out must not change.
- flush (synchronous):
  - next state is occ=0, out_valid=0, in_ready=1.
  - An op presented in the same cycle as flush is dropped even if in_valid=1.
  - flush has priority over accept and pop.
- Reset (rst_n=0 at an edge): occ=0, out_valid=0, in_ready=1, result=0, zero=1, illegal=0, rd_out=0.
  - Reset asserted mid-stream discards buffered ops identically to flush.
  - In the first cycle after rst_n deasserts, in_ready=1.
- When out_valid=0, the data outputs hold their last values and carry no meaning. At reset they take the values listed above.

Decomposition:
- Shared package rv_alu_pkg:
  - op-code constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110;
  - XLEN default;
  - entry struct {result, zero, illegal, rd}.
  - The ALU control decoder must use the same constants.
- One natural sub-module: alu_core. It is purely combinational: (op, a, b) -> (result, zero, illegal). It is instantiated once at the input side.
- The buffer/handshake logic stays in alu_exec_stage.

Test Plan:
- Reset then basic ops: rst_n=0 for 2 cycles, then check in_ready=1, out_valid=0, zero=1. Send ADD a=5, b=7, rd=3 with out_ready=1 -> next cycle out_valid=1, result=12, zero=0, rd_out=3, illegal=0.
- Arithmetic and edges:
  - SUB a=9, b=9 -> result=0, zero=1.
  - ADD a=FFFFFFFF, b=1 -> result=0, zero=1 (wrap).
  - SUB a=0, b=1 -> FFFFFFFF.
  - AND F0F0F0F0 & 0FF00FF0 -> 00F000F0.
  - OR 0 | 0 -> 0, zero=1.
  - op=4'b0111 -> illegal=1, result=0.
- Backpressure fill: out_ready=0, send 3 back-to-back ops (ADD 1+1, ADD 2+2, ADD 3+3). Expect:
  - first two accepted, then in_ready=0 and the third held by upstream;
  - outputs stay at result=2.
  - Then raise out_ready -> results 2, 4, 6 in order, with no gaps once the third is accepted.
- Streaming: out_ready=1 and in_valid=1 for 16 cycles with ADD i+i -> one result per cycle, values 0, 2, ..., 30; in_ready never drops.
- Flush: fill 2 entries with out_ready=0, then assert flush together with in_valid=1 (ADD 8+8) -> next cycle out_valid=0, in_ready=1, and result 16 never appears.
- Mid-stream reset: occ=2, assert rst_n=0 for one cycle -> out_valid=0, in_ready=1, result=0, zero=1, rd_out=0. A subsequent op completes normally.
